// File: rtl/sr_cmd_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : sr_cmd_debouncer
// Desc     : Synchronises, debounces and edge-detects two push-button inputs
//            into mutually exclusive single-cycle s/r command pulses.
//            Optional lockout after a conflict: define SR_CMD_LOCKOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sr_cmd_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_set,
  input  logic i_btn_rst,
  output logic o_s,
  output logic o_r,
  output logic o_conflict,
  output logic o_locked
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE_LOW     = 2'd0,
    CONFIRM_HIGH = 2'd1,
    IDLE_HIGH    = 2'd2,
    CONFIRM_LOW  = 2'd3
  } state_t;

  logic [1:0] w_btn;
  logic [1:0] w_req;

  assign w_btn = {i_btn_rst, i_btn_set};

  // Channel 0 is the set request, channel 1 the reset request.
  generate
    for (genvar g = 0; g < 2; g++) begin : g_ch
      logic [SYNC_STAGES-1:0] r_sync;
      logic                   w_x_sync;
      state_t                 r_state;
      state_t                 w_state_nxt;
      logic [CNT_W-1:0]       r_cnt;
      logic [CNT_W-1:0]       w_cnt_nxt;
      logic                   r_req;
      logic                   w_req_nxt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sync <= '0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], w_btn[g]};
        end
      end

      assign w_x_sync = r_sync[SYNC_STAGES-1];

      // A full count wins over the sample on that edge, so exactly
      // DEBOUNCE_CYCLES matching samples are enough to accept a change.
      always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req_nxt   = 1'b0;
        case (r_state)
          IDLE_LOW: begin
            if (w_x_sync) begin
              w_state_nxt = CONFIRM_HIGH;
              w_cnt_nxt   = C_CNT_ONE;
            end
          end
          CONFIRM_HIGH: begin
            if (r_cnt == C_CNT_MAX) begin
              w_state_nxt = IDLE_HIGH;
              w_cnt_nxt   = '0;
              w_req_nxt   = 1'b1;
            end else if (!w_x_sync) begin
              w_state_nxt = IDLE_LOW;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt   = r_cnt + C_CNT_ONE;
            end
          end
          IDLE_HIGH: begin
            if (!w_x_sync) begin
              w_state_nxt = CONFIRM_LOW;
              w_cnt_nxt   = C_CNT_ONE;
            end
          end
          CONFIRM_LOW: begin
            if (r_cnt == C_CNT_MAX) begin
              w_state_nxt = IDLE_LOW;
              w_cnt_nxt   = '0;
            end else if (w_x_sync) begin
              w_state_nxt = IDLE_HIGH;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt   = r_cnt + C_CNT_ONE;
            end
          end
          default: begin
            w_state_nxt = IDLE_LOW;
            w_cnt_nxt   = '0;
          end
        endcase
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_state <= IDLE_LOW;
          r_cnt   <= '0;
          r_req   <= 1'b0;
        end else begin
          r_state <= w_state_nxt;
          r_cnt   <= w_cnt_nxt;
          r_req   <= w_req_nxt;
        end
      end

      assign w_req[g] = r_req;
    end
  endgenerate

  logic r_s;
  logic r_r;
  logic r_conflict;
  logic w_both;

  assign w_both = w_req[0] & w_req[1];

`ifdef SR_CMD_LOCKOUT_EN
  logic r_locked;
  logic w_all_idle_low;

  assign w_all_idle_low = (g_ch[0].r_state == IDLE_LOW) &&
                          (g_ch[1].r_state == IDLE_LOW);

  // Requests seen while locked are dropped, including a second conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_conflict <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_s        <= w_req[0] & ~w_req[1] & ~r_locked;
      r_r        <= w_req[1] & ~w_req[0] & ~r_locked;
      r_conflict <= w_both & ~r_locked;
      if (w_both && !r_locked) begin
        r_locked <= 1'b1;
      end else if (w_all_idle_low) begin
        r_locked <= 1'b0;
      end
    end
  end

  assign o_locked = r_locked;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_s        <= w_req[0] & ~w_req[1];
      r_r        <= w_req[1] & ~w_req[0];
      r_conflict <= w_both;
    end
  end

  assign o_locked = 1'b0;
`endif

  assign o_s        = r_s;
  assign o_r        = r_r;
  assign o_conflict = r_conflict;

endmodule
`default_nettype wire

// File: tb/tb_sr_cmd_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_cmd_debouncer
// Desc     : Self-checking bench for sr_cmd_debouncer (default build, L = 7).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_cmd_debouncer;

  localparam int C_SYNC = 2;
  localparam int C_DEB  = 4;
  localparam int C_LAT  = C_SYNC + C_DEB + 1;

  logic clk;
  logic rst;
  logic i_btn_set;
  logic i_btn_rst;
  logic o_s;
  logic o_r;
  logic o_conflict;
  logic o_locked;

  int checks = 0;
  int errors = 0;

  sr_cmd_debouncer #(
    .SYNC_STAGES    (C_SYNC),
    .DEBOUNCE_CYCLES(C_DEB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_btn_set  (i_btn_set),
    .i_btn_rst  (i_btn_rst),
    .o_s        (o_s),
    .o_r        (o_r),
    .o_conflict (o_conflict),
    .o_locked   (o_locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: raw history delayed by the synchroniser, a debounced
  // level per channel, and a run length of samples disagreeing with it.
  bit m_hist [2][C_SYNC];
  bit m_lvl  [2];
  int m_run  [2];
  bit m_req  [2];
  bit exp_s, exp_r, exp_c;

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < C_SYNC; k++) m_hist[c][k] = 1'b0;
      m_lvl[c] = 1'b0;
      m_run[c] = 0;
      m_req[c] = 1'b0;
    end
    exp_s = 1'b0;
    exp_r = 1'b0;
    exp_c = 1'b0;
  endfunction

  function automatic void model_step(input bit bs, input bit br);
    bit raw [2];
    bit samp;
    raw[0] = bs;
    raw[1] = br;
    exp_s = m_req[0] && !m_req[1];
    exp_r = m_req[1] && !m_req[0];
    exp_c = m_req[0] && m_req[1];
    for (int c = 0; c < 2; c++) begin
      samp = m_hist[c][C_SYNC-1];
      for (int k = C_SYNC - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
      m_hist[c][0] = raw[c];
      m_req[c] = 1'b0;
      if (m_run[c] == C_DEB) begin
        m_lvl[c] = !m_lvl[c];
        m_run[c] = 0;
        m_req[c] = m_lvl[c];
      end else if (samp != m_lvl[c]) begin
        m_run[c] = m_run[c] + 1;
      end else begin
        m_run[c] = 0;
      end
    end
  endfunction

  // One clock: drive on the falling edge, step the model on the rising edge,
  // leave the caller 1 time unit after the rising edge to sample.
  task automatic cycle(input bit bs, input bit br, input bit rr);
    @(negedge clk);
    i_btn_set = bs;
    i_btn_rst = br;
    rst       = rr;
    @(posedge clk);
    if (rr) model_reset();
    else    model_step(bs, br);
    #1;
  endtask

  task automatic settle();
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      checks++;
      if (o_s !== exp_s || o_r !== exp_r || o_conflict !== exp_c) begin
        errors++;
        $display("FAIL settle cyc=%0d got s/r/c=%b%b%b want %b%b%b", i, o_s, o_r, o_conflict, exp_s, exp_r, exp_c);
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b1);
      checks++;
      if ({o_s, o_r, o_conflict, o_locked} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got %b want 0000", i, {o_s, o_r, o_conflict, o_locked});
      end
    end
    settle();
  endtask

  task automatic test_press();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      checks++;
      if (o_s !== (i == C_LAT) || o_r !== 1'b0 || o_conflict !== 1'b0 || o_locked !== 1'b0) begin
        errors++;
        $display("FAIL press cyc=%0d got s/r/c/l=%b%b%b%b want s=%b", i, o_s, o_r, o_conflict, o_locked, (i == C_LAT));
      end
    end
    settle();
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, (i < 3), 1'b0);
      checks++;
      if (o_r !== 1'b0 || o_r !== exp_r) begin
        errors++;
        $display("FAIL glitch3 cyc=%0d got r=%b want 0", i, o_r);
      end
    end
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, (i < 4), 1'b0);
      checks++;
      if (o_r !== (i == C_LAT) || o_s !== 1'b0 || o_r !== exp_r) begin
        errors++;
        $display("FAIL press4 cyc=%0d got s/r=%b%b want r=%b", i, o_s, o_r, (i == C_LAT));
      end
    end
    settle();
  endtask

  task automatic test_conflict();
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      checks++;
      if (o_s !== 1'b0 || o_r !== 1'b0 || o_conflict !== (i == C_LAT) || o_locked !== 1'b0) begin
        errors++;
        $display("FAIL conflict cyc=%0d got s/r/c/l=%b%b%b%b want c=%b", i, o_s, o_r, o_conflict, o_locked, (i == C_LAT));
      end
    end
    settle();
  endtask

  task automatic test_back_to_back();
    bit pat [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      if (o_s) pulses++;
    end
    for (int i = 0; i < 4; i++) begin
      cycle(pat[i], 1'b0, 1'b0);
      if (o_s) pulses++;
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (o_s) pulses++;
    end
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      if (o_s) pulses++;
      checks++;
      if (o_s !== (i == C_LAT) || o_s !== exp_s) begin
        errors++;
        $display("FAIL second_press cyc=%0d got s=%b want %b", i, o_s, (i == C_LAT));
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL pulse_count got %0d want 2", pulses);
    end
    settle();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b0, 1'b1);
      checks++;
      if ({o_s, o_r, o_conflict, o_locked} !== 4'b0000) begin
        errors++;
        $display("FAIL mid_reset cyc=%0d got %b want 0000", i, {o_s, o_r, o_conflict, o_locked});
      end
    end
    for (int i = 0; i < 14; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      checks++;
      if (o_s !== (i == C_LAT) || o_r !== 1'b0 || o_s !== exp_s) begin
        errors++;
        $display("FAIL after_reset cyc=%0d got s/r=%b%b want s=%b", i, o_s, o_r, (i == C_LAT));
      end
    end
    settle();
  endtask

  task automatic test_random();
    bit tgt_s = 1'b0;
    bit tgt_r = 1'b0;
    bit bs, br;
    bit prev_s = 1'b0;
    bit prev_r = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 29) == 0) tgt_s = !tgt_s;
      if ($urandom_range(0, 29) == 0) tgt_r = !tgt_r;
      bs = ($urandom_range(0, 5) == 0) ? !tgt_s : tgt_s;
      br = ($urandom_range(0, 5) == 0) ? !tgt_r : tgt_r;
      cycle(bs, br, 1'b0);
      checks++;
      if (o_s !== exp_s || o_r !== exp_r || o_conflict !== exp_c || o_locked !== 1'b0) begin
        errors++;
        $display("FAIL random cyc=%0d got s/r/c/l=%b%b%b%b want %b%b%b0", i, o_s, o_r, o_conflict, o_locked, exp_s, exp_r, exp_c);
      end
      checks++;
      if ((o_s && o_r) || (o_s && prev_s) || (o_r && prev_r)) begin
        errors++;
        $display("FAIL invariant cyc=%0d got s=%b r=%b prev_s=%b prev_r=%b", i, o_s, o_r, prev_s, prev_r);
      end
      prev_s = o_s;
      prev_r = o_r;
    end
  endtask

  initial begin
    rst       = 1'b1;
    i_btn_set = 1'b0;
    i_btn_rst = 1'b0;
    model_reset();
    test_reset();
    test_press();
    test_glitch();
    test_conflict();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
